// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage with the IF/ID pipeline register.
//               Holds the PC, drives the instruction-memory address and
//               predicts the next PC from a direct-mapped BTB whose entries
//               carry 2-bit saturating direction counters. Honours stall,
//               flush and EX-stage redirect controls from the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_en,
  input  logic        if_id_en,
  input  logic        if_id_flush,
  input  logic        modify_pc_ex,
  input  logic [31:0] update_pc_ex,
  input  logic        ex_btb_update,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        if_id_pred_taken,
  output logic [31:0] if_id_pred_target
);

  localparam int unsigned c_idx   = $clog2(BTB_ENTRIES);
  localparam int unsigned c_tag_w = 32 - c_idx - 2;
  localparam logic [31:0] c_nop   = 32'h0000_0013;

  // Program counter and IF/ID register
  logic [31:0]        r_pc;
  logic [31:0]        r_if_id_pc;
  logic [31:0]        r_if_id_instr;
  logic               r_if_id_valid;
  logic               r_if_id_pred_taken;
  logic [31:0]        r_if_id_pred_target;

  // BTB storage
  logic               r_btb_valid  [BTB_ENTRIES];
  logic [c_tag_w-1:0] r_btb_tag    [BTB_ENTRIES];
  logic [31:0]        r_btb_target [BTB_ENTRIES];
  logic [1:0]         r_btb_ctr    [BTB_ENTRIES];

  // Lookup side (indexed by the current PC)
  logic [c_idx-1:0]   w_rd_idx;
  logic [c_tag_w-1:0] w_rd_tag;
  logic               w_rd_hit;
  logic               w_pred_taken;
  logic [31:0]        w_pred_target;

  // Update side (indexed by the resolved EX PC)
  logic [31:0]        w_ex_pc_word;
  logic [c_idx-1:0]   w_wr_idx;
  logic [c_tag_w-1:0] w_wr_tag;
  logic               w_wr_hit;

  logic [31:0]        w_redirect_pc;
  logic [31:0]        w_pc_next;

  // BTB lookup: hit needs a valid entry with matching tag; taken needs ctr MSB
  always_comb begin
    w_rd_idx      = r_pc[c_idx+1:2];
    w_rd_tag      = r_pc[31:c_idx+2];
    w_rd_hit      = r_btb_valid[w_rd_idx] && (r_btb_tag[w_rd_idx] == w_rd_tag);
    w_pred_taken  = w_rd_hit && r_btb_ctr[w_rd_idx][1];
    w_pred_target = w_pred_taken ? r_btb_target[w_rd_idx] : 32'h0000_0000;
  end

  // BTB update addressing; the low two bits of the EX PC are never meaningful
  always_comb begin
    w_ex_pc_word = ex_pc & 32'hFFFF_FFFC;
    w_wr_idx     = w_ex_pc_word[c_idx+1:2];
    w_wr_tag     = w_ex_pc_word[31:c_idx+2];
    w_wr_hit     = r_btb_valid[w_wr_idx] && (r_btb_tag[w_wr_idx] == w_wr_tag);
  end

  // Next-PC selection: redirect beats stall, stall beats prediction
  always_comb begin
    w_redirect_pc = update_pc_ex & 32'hFFFF_FFFC;
    w_pc_next     = r_pc + 32'd4;
    if (modify_pc_ex) begin
      w_pc_next = w_redirect_pc;
    end else if (!pc_en) begin
      w_pc_next = r_pc;
    end else if (w_pred_taken) begin
      w_pc_next = w_pred_target;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // BTB training; writes land after the edge so same-cycle lookups see old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb_valid[i]  <= 1'b0;
        r_btb_tag[i]    <= '0;
        r_btb_target[i] <= 32'h0000_0000;
        r_btb_ctr[i]    <= 2'b00;
      end
    end else if (ex_btb_update) begin
      if (w_wr_hit) begin
        if (ex_taken) begin
          r_btb_target[w_wr_idx] <= ex_target;
          if (r_btb_ctr[w_wr_idx] != 2'b11) begin
            r_btb_ctr[w_wr_idx] <= r_btb_ctr[w_wr_idx] + 2'd1;
          end
        end else if (r_btb_ctr[w_wr_idx] != 2'b00) begin
          r_btb_ctr[w_wr_idx] <= r_btb_ctr[w_wr_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        r_btb_valid[w_wr_idx]  <= 1'b1;
        r_btb_tag[w_wr_idx]    <= w_wr_tag;
        r_btb_target[w_wr_idx] <= ex_target;
        r_btb_ctr[w_wr_idx]    <= 2'b10;
      end
    end
  end

  // IF/ID register: flush inserts a NOP and wins over capture enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id_pc          <= 32'h0000_0000;
      r_if_id_instr       <= c_nop;
      r_if_id_valid       <= 1'b0;
      r_if_id_pred_taken  <= 1'b0;
      r_if_id_pred_target <= 32'h0000_0000;
    end else if (if_id_flush) begin
      r_if_id_pc          <= 32'h0000_0000;
      r_if_id_instr       <= c_nop;
      r_if_id_valid       <= 1'b0;
      r_if_id_pred_taken  <= 1'b0;
      r_if_id_pred_target <= 32'h0000_0000;
    end else if (if_id_en) begin
      r_if_id_pc          <= r_pc;
      r_if_id_instr       <= imem_rdata;
      r_if_id_valid       <= 1'b1;
      r_if_id_pred_taken  <= w_pred_taken;
      r_if_id_pred_target <= w_pred_target;
    end
  end

  assign imem_addr         = r_pc;
  assign if_id_pc          = r_if_id_pc;
  assign if_id_instr       = r_if_id_instr;
  assign if_id_valid       = r_if_id_valid;
  assign if_id_pred_taken  = r_if_id_pred_taken;
  assign if_id_pred_target = r_if_id_pred_target;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A reference model of the
//               PC, BTB and IF/ID register predicts each cycle's result; the
//               expected IF/ID contents are queued when stimulus is applied
//               and compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam int unsigned c_entries = 16;
  localparam logic [31:0] c_nop     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        pt;
    logic [31:0] ptgt;
  } ifid_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_en, if_id_en, if_id_flush, modify_pc_ex, ex_btb_update, ex_taken;
  logic [31:0] update_pc_ex, ex_pc, ex_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_pc, if_id_instr, if_id_pred_target;
  logic        if_id_valid, if_id_pred_taken;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  ifid_t       m_ifid;
  logic        m_v   [c_entries];
  logic [25:0] m_tag [c_entries];
  logic [31:0] m_tgt [c_entries];
  logic [1:0]  m_ctr [c_entries];
  ifid_t       sb_q[$];

  fetch_stage #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(c_entries)) dut (
    .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .modify_pc_ex(modify_pc_ex),
    .update_pc_ex(update_pc_ex), .ex_btb_update(ex_btb_update),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .if_id_pred_taken(if_id_pred_taken), .if_id_pred_target(if_id_pred_target)
  );

  always #5 clk = ~clk;

  // Instruction memory: a distinct, recognisable word per address
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'hCAFE_0000;
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  task automatic model_reset();
    m_pc   = 32'h0000_0000;
    m_ifid = {32'h0, c_nop, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < c_entries; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b00;
    end
    sb_q.delete();
  endtask

  // Apply one cycle of stimulus at posedge+1, queue the expectation, compare after the edge
  task automatic step(input logic pe, input logic ie, input logic fl, input logic mod,
                      input logic [31:0] upc, input logic bu, input logic [31:0] epc,
                      input logic tk, input logic [31:0] etgt);
    logic [3:0]  ridx, widx;
    logic        hit, whit, pt;
    logic [31:0] ptgt, npc;
    ifid_t       exp;
    pc_en = pe; if_id_en = ie; if_id_flush = fl; modify_pc_ex = mod; update_pc_ex = upc;
    ex_btb_update = bu; ex_pc = epc; ex_taken = tk; ex_target = etgt;
    #1;
    n_checks++;
    if (imem_addr !== m_pc) begin
      n_fail++;
      $display("FAIL imem_addr: got %h expected %h", imem_addr, m_pc);
    end
    ridx = m_pc[5:2];
    hit  = m_v[ridx] && (m_tag[ridx] == m_pc[31:6]);
    pt   = hit && m_ctr[ridx][1];
    ptgt = pt ? m_tgt[ridx] : 32'h0;
    if (fl) m_ifid = {32'h0, c_nop, 1'b0, 1'b0, 32'h0};
    else if (ie) m_ifid = {m_pc, instr_of(m_pc), 1'b1, pt, ptgt};
    sb_q.push_back(m_ifid);
    if (mod) npc = {upc[31:2], 2'b00};
    else if (!pe) npc = m_pc;
    else if (pt) npc = ptgt;
    else npc = m_pc + 32'd4;
    if (bu) begin
      widx = epc[5:2];
      whit = m_v[widx] && (m_tag[widx] == epc[31:6]);
      if (whit) begin
        if (tk) begin
          m_tgt[widx] = etgt;
          if (m_ctr[widx] != 2'b11) m_ctr[widx] = m_ctr[widx] + 2'd1;
        end else if (m_ctr[widx] != 2'b00) m_ctr[widx] = m_ctr[widx] - 2'd1;
      end else if (tk) begin
        m_v[widx] = 1'b1; m_tag[widx] = epc[31:6]; m_tgt[widx] = etgt; m_ctr[widx] = 2'b10;
      end
    end
    m_pc = npc;
    @(posedge clk); #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      exp = sb_q.pop_front();
      n_checks += 4;
      if (if_id_pc !== exp.pc) begin n_fail++; $display("FAIL if_id_pc: got %h expected %h", if_id_pc, exp.pc); end
      if (if_id_instr !== exp.instr) begin n_fail++; $display("FAIL if_id_instr: got %h expected %h", if_id_instr, exp.instr); end
      if (if_id_valid !== exp.valid) begin n_fail++; $display("FAIL if_id_valid: got %b expected %b", if_id_valid, exp.valid); end
      if ({if_id_pred_taken, if_id_pred_target} !== {exp.pt, exp.ptgt}) begin
        n_fail++;
        $display("FAIL if_id_pred: got %b/%h expected %b/%h", if_id_pred_taken, if_id_pred_target, exp.pt, exp.ptgt);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input logic [31:0] target);
    step(1, 1, 0, 1, target, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pc_en = 1; if_id_en = 1; if_id_flush = 0; modify_pc_ex = 0; update_pc_ex = 0;
    ex_btb_update = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 5;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", imem_addr); end
    if (if_id_instr !== c_nop) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000013", if_id_instr); end
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
    if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ifid_pc: got %h expected 0", if_id_pc); end
    if ({if_id_pred_taken, if_id_pred_target} !== 33'h0) begin
      n_fail++; $display("FAIL reset_pred: got %b/%h expected 0/0", if_id_pred_taken, if_id_pred_target);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_sequential();
    run(2);
    n_checks += 2;
    if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq_addr: got %h expected 00000008", imem_addr); end
    if (if_id_pc !== 32'h4) begin n_fail++; $display("FAIL seq_ifid_pc: got %h expected 00000004", if_id_pc); end
  endtask

  task automatic test_load_stall();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks += 2;
    if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_addr: got %h expected 00000008", imem_addr); end
    if (if_id_pc !== 32'h4) begin n_fail++; $display("FAIL stall_ifid_pc: got %h expected 00000004", if_id_pc); end
    run(1);
    n_checks++;
    if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL resume_addr: got %h expected 0000000c", imem_addr); end
  endtask

  task automatic test_redirect();
    step(0, 1, 1, 1, 32'h103, 0, 0, 0, 0);
    n_checks += 2;
    if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redirect_addr: got %h expected 00000100", imem_addr); end
    if ({if_id_valid, if_id_instr} !== {1'b0, c_nop}) begin
      n_fail++; $display("FAIL redirect_flush: got %b/%h expected 0/00000013", if_id_valid, if_id_instr);
    end
    run(1);
  endtask

  task automatic test_btb();
    // Redirect to 0x20 in the same cycle the first training update arrives
    step(1, 1, 0, 1, 32'h20, 1, 32'h20, 1, 32'h80);
    run(1);
    n_checks += 2;
    if (imem_addr !== 32'h80) begin n_fail++; $display("FAIL btb_pred_addr: got %h expected 00000080", imem_addr); end
    if ({if_id_pred_taken, if_id_pred_target} !== {1'b1, 32'h80}) begin
      n_fail++; $display("FAIL btb_pred: got %b/%h expected 1/00000080", if_id_pred_taken, if_id_pred_target);
    end
    step(1, 1, 0, 0, 0, 1, 32'h20, 0, 0);
    step(1, 1, 0, 0, 0, 1, 32'h20, 0, 0);
    redirect(32'h20);
    run(1);
    n_checks += 2;
    if (imem_addr !== 32'h24) begin n_fail++; $display("FAIL btb_weak_addr: got %h expected 00000024", imem_addr); end
    if (if_id_pred_taken !== 1'b0) begin n_fail++; $display("FAIL btb_weak_pred: got %b expected 0", if_id_pred_taken); end
  endtask

  task automatic test_alias();
    step(1, 1, 0, 0, 0, 1, 32'h20, 1, 32'h80);
    step(1, 1, 0, 0, 0, 1, 32'h20, 1, 32'h80);
    redirect(32'h20 + 4 * c_entries);
    run(1);
    n_checks++;
    if (imem_addr !== 32'h64) begin n_fail++; $display("FAIL alias_addr: got %h expected 00000064", imem_addr); end
    redirect(32'h20);
    run(1);
    n_checks++;
    if (imem_addr !== 32'h80) begin n_fail++; $display("FAIL retrain_addr: got %h expected 00000080", imem_addr); end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    run(1);
    n_checks += 2;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00000000", imem_addr); end
    if (if_id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_ifid_pc: got %h expected fffffffc", if_id_pc); end
    run(2);
  endtask

  task automatic test_reset_midrun();
    // A redirect and a training update are pending when reset asserts
    modify_pc_ex = 1; update_pc_ex = 32'h200; ex_btb_update = 1; ex_pc = 32'h40; ex_taken = 1; ex_target = 32'h300;
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL midreset_pc: got %h expected 00000000", imem_addr); end
    if (if_id_instr !== c_nop) begin n_fail++; $display("FAIL midreset_instr: got %h expected 00000013", if_id_instr); end
    if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", if_id_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    run(1);
    redirect(32'h20);
    run(1);
    redirect(32'h40);
    run(1);
    n_checks++;
    if (imem_addr !== 32'h44) begin n_fail++; $display("FAIL midreset_btb: got %h expected 00000044", imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_load_stall();
    test_redirect();
    test_btb();
    test_alias();
    test_wrap();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
